// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux.
//   in_data/in_valid/in_last : N producer channels (channel i at [i*NBITS +: NBITS])
//   in_ready                 : per-channel accept, one-hot or zero
//   out_data/out_sel/out_last/out_valid : registered output word and its source
//   out_ready                : consumer accept
// master = producers + consumer side, slave = the arbitrating mux.
interface rr_arb_mux_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned NBITS = 16
);
  localparam int unsigned SELW = $clog2(N);

  logic [N*NBITS-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [NBITS-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_sel, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_sel, out_last, out_valid
  );
endinterface

// File: rtl/rr_arb_mux.sv
// Registered N-to-1 arbitrating multiplexer with burst locking.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rr_arb_mux_if slave view (N input channels, one output register)
// MODE 0 = round-robin (pointer advances past a channel on its last word),
// MODE 1 = fixed priority, lowest index wins.
module rr_arb_mux #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = 0
) (
  input logic        clk,
  input logic        rst_n,
  rr_arb_mux_if.slave bus
);
  localparam int unsigned SELW = $clog2(N);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t            state, state_nxt;
  logic [SELW-1:0]   ptr, lock_ch;
  logic [SELW-1:0]   gnt, idx;
  logic              gnt_valid;
  logic              can_load, xfer;
  logic [N-1:0]      ready;
  logic [NBITS-1:0]  words [N];

  logic [NBITS-1:0]  out_data_q;
  logic [SELW-1:0]   out_sel_q;
  logic              out_last_q;
  logic              out_valid_q;

  // Unpack the flat channel bus so the grant can index it directly.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      words[i] = bus.in_data[i*NBITS +: NBITS];
    end
  end

  assign can_load = ~out_valid_q | bus.out_ready;
  assign xfer     = can_load & gnt_valid;

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_OPEN;
    else        state <= state_nxt;
  end

  // Lock next-state: a non-last word locks, a last word unlocks.
  always_comb begin
    state_nxt = state;
    if (xfer) state_nxt = bus.in_last[gnt] ? ST_OPEN : ST_LOCKED;
  end

  // Grant: locked channel, else first requester from ptr upward with wrap.
  // In fixed-priority mode ptr never moves from 0, so the scan is lowest-first.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    if (state == ST_LOCKED) begin
      gnt       = lock_ch;
      gnt_valid = bus.in_valid[lock_ch];
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        idx = SELW'((int'(ptr) + k) % int'(N));
        if (!gnt_valid && bus.in_valid[idx]) begin
          gnt_valid = 1'b1;
          gnt       = idx;
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    if (can_load && gnt_valid) ready[gnt] = 1'b1;
  end

  // Output register, burst lock channel and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      lock_ch     <= '0;
      ptr         <= '0;
    end else if (xfer) begin
      out_data_q  <= words[gnt];
      out_sel_q   <= gnt;
      out_last_q  <= bus.in_last[gnt];
      out_valid_q <= 1'b1;
      if (!bus.in_last[gnt]) begin
        lock_ch <= gnt;
      end else if (MODE == 0) begin
        ptr <= SELW'((int'(gnt) + 1) % int'(N));
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a round-robin instance (bus0) and a
// fixed-priority instance (bus1) share clock and reset.
module tb_rr_arb_mux;
  localparam int unsigned N     = 4;
  localparam int unsigned NBITS = 16;

  typedef struct {
    bit          m;        // 0 = round-robin dut, 1 = fixed-priority dut
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        ordy;
    logic [7:0]  tag;
    logic [3:0]  exp_rdy;  // in_ready before the edge
    logic        exp_ov;   // outputs after the edge
    logic [1:0]  exp_sel;
    logic        exp_last;
    logic [15:0] exp_data;
    string       name;
  } vec_t;

  logic clk;
  logic rst_n;
  int   nchk;
  int   nerr;
  vec_t vq[$];

  rr_arb_mux_if #(.N(N), .NBITS(NBITS)) bus0 ();
  rr_arb_mux_if #(.N(N), .NBITS(NBITS)) bus1 ();

  rr_arb_mux #(.NBITS(NBITS), .N(N), .MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  rr_arb_mux #(.NBITS(NBITS), .N(N), .MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] w(int ch, logic [7:0] tag);
    return 16'(32'h0000_A000 + (ch << 8) + 32'(tag));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(bit m, logic [3:0] valid, logic [3:0] last, logic ordy, logic [7:0] tag,
                     logic [3:0] exp_rdy, logic exp_ov, logic [1:0] exp_sel, logic exp_last,
                     logic [15:0] exp_data, string name);
    vec_t v;
    v.m = m; v.valid = valid; v.last = last; v.ordy = ordy; v.tag = tag;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_sel = exp_sel; v.exp_last = exp_last;
    v.exp_data = exp_data; v.name = name;
    vq.push_back(v);
  endtask

  task automatic drive(bit m, logic [3:0] valid, logic [3:0] last, logic ordy, logic [7:0] tag);
    logic [N*NBITS-1:0] d;
    for (int i = 0; i < int'(N); i++) d[i*NBITS +: NBITS] = w(i, tag);
    if (m) begin
      bus1.in_data = d; bus1.in_valid = valid; bus1.in_last = last; bus1.out_ready = ordy;
      bus0.in_valid = '0; bus0.out_ready = 1'b0;
    end else begin
      bus0.in_data = d; bus0.in_valid = valid; bus0.in_last = last; bus0.out_ready = ordy;
      bus1.in_valid = '0; bus1.out_ready = 1'b0;
    end
  endtask

  // Drive one cycle away from the edge, check in_ready, clock, check outputs.
  task automatic apply(vec_t v);
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  sel;
    logic        lst;
    logic [15:0] dat;
    drive(v.m, v.valid, v.last, v.ordy, v.tag);
    #1;
    rdy = v.m ? bus1.in_ready : bus0.in_ready;
    chk({v.name, " in_ready"}, 32'(rdy), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    ov  = v.m ? bus1.out_valid : bus0.out_valid;
    sel = v.m ? bus1.out_sel   : bus0.out_sel;
    lst = v.m ? bus1.out_last  : bus0.out_last;
    dat = v.m ? bus1.out_data  : bus0.out_data;
    chk({v.name, " out_valid"}, 32'(ov),  32'(v.exp_ov));
    chk({v.name, " out_sel"},   32'(sel), 32'(v.exp_sel));
    chk({v.name, " out_last"},  32'(lst), 32'(v.exp_last));
    chk({v.name, " out_data"},  32'(dat), 32'(v.exp_data));
  endtask

  task automatic step(bit m, logic [3:0] valid, logic [3:0] last, logic ordy, logic [7:0] tag,
                      logic [3:0] exp_rdy, logic exp_ov, logic [1:0] exp_sel, logic exp_last,
                      logic [15:0] exp_data, string name);
    vec_t v;
    v.m = m; v.valid = valid; v.last = last; v.ordy = ordy; v.tag = tag;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_sel = exp_sel; v.exp_last = exp_last;
    v.exp_data = exp_data; v.name = name;
    apply(v);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00);

    // Round-robin: every channel single-word, one grant per cycle 0,1,2,3,0.
    add(0, 4'b1111, 4'b1111, 1, 8'd0,  4'b0001, 1, 2'd0, 1, w(0, 8'd0),  "rr0");
    add(0, 4'b1111, 4'b1111, 1, 8'd1,  4'b0010, 1, 2'd1, 1, w(1, 8'd1),  "rr1");
    add(0, 4'b1111, 4'b1111, 1, 8'd2,  4'b0100, 1, 2'd2, 1, w(2, 8'd2),  "rr2");
    add(0, 4'b1111, 4'b1111, 1, 8'd3,  4'b1000, 1, 2'd3, 1, w(3, 8'd3),  "rr3");
    add(0, 4'b1111, 4'b1111, 1, 8'd4,  4'b0001, 1, 2'd0, 1, w(0, 8'd4),  "rr4");
    add(0, 4'b0000, 4'b0000, 1, 8'd5,  4'b0000, 0, 2'd0, 1, w(0, 8'd4),  "drain0");
    // ch1 burst of 3 with ch0/ch2 competing; ch1 stalls 2 cycles mid-burst.
    add(0, 4'b0111, 4'b0101, 1, 8'd10, 4'b0010, 1, 2'd1, 0, w(1, 8'd10), "burst1");
    add(0, 4'b0111, 4'b0101, 1, 8'd11, 4'b0010, 1, 2'd1, 0, w(1, 8'd11), "burst2");
    add(0, 4'b0101, 4'b0101, 1, 8'd12, 4'b0000, 0, 2'd1, 0, w(1, 8'd11), "stall1");
    add(0, 4'b0101, 4'b0101, 1, 8'd13, 4'b0000, 0, 2'd1, 0, w(1, 8'd11), "stall2");
    add(0, 4'b0111, 4'b0111, 1, 8'd14, 4'b0010, 1, 2'd1, 1, w(1, 8'd14), "burst3");
    // ch1 keeps requesting after its last word but ch2 is next.
    add(0, 4'b0111, 4'b0111, 1, 8'd15, 4'b0100, 1, 2'd2, 1, w(2, 8'd15), "after_burst");
    // Backpressure for 3 cycles: output holds, nothing accepted.
    add(0, 4'b0111, 4'b0111, 0, 8'd16, 4'b0000, 1, 2'd2, 1, w(2, 8'd15), "bp1");
    add(0, 4'b0111, 4'b0111, 0, 8'd17, 4'b0000, 1, 2'd2, 1, w(2, 8'd15), "bp2");
    add(0, 4'b0111, 4'b0111, 0, 8'd18, 4'b0000, 1, 2'd2, 1, w(2, 8'd15), "bp3");
    add(0, 4'b0111, 4'b0111, 1, 8'd19, 4'b0001, 1, 2'd0, 1, w(0, 8'd19), "bp_release");
    add(0, 4'b0111, 4'b0111, 1, 8'd20, 4'b0010, 1, 2'd1, 1, w(1, 8'd20), "bp_next");
    add(0, 4'b0000, 4'b0000, 1, 8'd21, 4'b0000, 0, 2'd1, 1, w(1, 8'd20), "drain1");
    // Fixed priority: ch1 beats ch3 until ch1 idles.
    add(1, 4'b1010, 4'b1111, 1, 8'd40, 4'b0010, 1, 2'd1, 1, w(1, 8'd40), "fp1");
    add(1, 4'b1010, 4'b1111, 1, 8'd41, 4'b0010, 1, 2'd1, 1, w(1, 8'd41), "fp2");
    add(1, 4'b1010, 4'b1111, 1, 8'd42, 4'b0010, 1, 2'd1, 1, w(1, 8'd42), "fp3");
    add(1, 4'b1000, 4'b1111, 1, 8'd43, 4'b1000, 1, 2'd3, 1, w(3, 8'd43), "fp_ch3");
    add(1, 4'b1010, 4'b1111, 1, 8'd44, 4'b0010, 1, 2'd1, 1, w(1, 8'd44), "fp_back");

    // Reset state with no requests.
    #12;
    chk("reset out_valid0", 32'(bus0.out_valid), 32'd0);
    chk("reset out_data0",  32'(bus0.out_data),  32'd0);
    chk("reset out_sel0",   32'(bus0.out_sel),   32'd0);
    chk("reset out_last0",  32'(bus0.out_last),  32'd0);
    chk("reset in_ready0",  32'(bus0.in_ready),  32'd0);
    chk("reset out_valid1", 32'(bus1.out_valid), 32'd0);
    chk("reset in_ready1",  32'(bus1.in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) apply(vq[i]);

    // ch2 starts a burst (ptr is 2 here), then reset lands mid-cycle.
    step(0, 4'b0100, 4'b0000, 1, 8'd30, 4'b0100, 1, 2'd2, 0, w(2, 8'd30), "ch2_burst");
    drive(0, 4'b0101, 4'b0101, 1'b1, 8'd31);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst out_valid", 32'(bus0.out_valid), 32'd0);
    chk("async_rst out_data",  32'(bus0.out_data),  32'd0);
    chk("async_rst out_sel",   32'(bus0.out_sel),   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // No lock and ptr=0: ch0 wins, then ch2 (scan from 1).
    step(0, 4'b0101, 4'b0101, 1, 8'd31, 4'b0001, 1, 2'd0, 1, w(0, 8'd31), "post_rst0");
    step(0, 4'b0101, 4'b0101, 1, 8'd32, 4'b0100, 1, 2'd2, 1, w(2, 8'd32), "post_rst1");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised, registered N-to-1 arbitrating multiplexer with valid/ready handshakes on every input channel and on the output. Each cycle it selects one requesting channel, by round-robin or fixed priority, and loads that channel's word into a single output register. An optional per-channel `last` flag locks the grant across multi-word bursts. It sits between multiple producers (fetch, memory, writeback sources) and a single shared consumer in the datapath, replacing static selector-driven muxes where sources compete.

## Interface
- `NBITS`, 16, data width per channel
- `N`, 4, number of input channels (N ≥ 2)
- `MODE`, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins)
- `SELW`, `$clog2(N)`, derived selector width; not overridden
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_data`  in  N*NBITS  channel i occupies bits [i*NBITS +: NBITS]
- `in_valid`  in  N  per-channel request
- `in_last`  in  N  per-channel end-of-burst flag, qualified by `in_valid`
- `in_ready`  out  N  per-channel accept; at most one bit high per cycle
- `out_data`  out  NBITS  registered selected word
- `out_sel`  out  SELW  index of the channel that produced `out_data`
- `out_last`  out  1  registered copy of the accepted `in_last`
- `out_valid`  out  1  output register holds a word
- `out_ready`  in  1  consumer accept

## Operation
- Transfer on channel i: `in_valid[i] & in_ready[i]` at a rising edge. Output transfer: `out_valid & out_ready`.
- `can_load = ~out_valid | out_ready`. An output drain and a new load may occur in the same cycle.
- Grant (combinational):
  - If locked, the grant is the locked channel.
  - Otherwise, MODE 0: first requesting channel scanning from `ptr` upward, wrapping N-1 → 0. MODE 1: lowest-index requesting channel.
  - No requester means no grant.
- `in_ready[i] = can_load & grant_valid & (grant == i)`. It does not depend combinationally on `in_valid[i]` of other channels beyond the grant computation.
- On an input transfer from channel g:
  - `out_data ← in_data[g]`, `out_sel ← g`, `out_last ← in_last[g]`, `out_valid ← 1`.
  - If `in_last[g]=0`: set lock, `lock_ch ← g`.
  - If `in_last[g]=1`: clear lock; in MODE 0, `ptr ← (g+1) mod N`.
- With no input transfer: if the output drained, `out_valid ← 0`. Data and selection registers hold.
- While locked, other channels are blocked even if the locked channel drops `in_valid`. No transfer occurs until it reasserts.
- `ptr` only advances on a last-word transfer. In MODE 1, `ptr` stays 0 and is unused.
- Single-word transactions use `in_last=1`.

## Timing
- Reset (async assert, sync release) values: `out_valid=0`, `out_data=0`, `out_sel=0`, `out_last=0`, lock cleared, `ptr=0`. `in_ready` is therefore combinationally 0 only if no requests are present.
- Latency: a word accepted at edge t is visible with `out_valid=1` after edge t. One cycle, input to output.
- Throughput: one word per cycle when `out_ready` is held high.
- Backpressure: with `out_valid=1` and `out_ready=0`, all `in_ready=0` and the output registers hold stable.
- Reset mid-burst: lock and `ptr` cleared; any held output word is discarded.
- Simultaneous last-word transfer and a new request from the same channel: the channel loses priority to any other requester next cycle (MODE 0).

## Test plan
- Reset with all `in_valid=0`: outputs all zero, `in_ready=0`. Assert `rst_n=0` asynchronously mid-cycle: `out_valid` falls immediately.
- MODE 0, N=4, all channels valid with `in_last=1`, `out_ready=1`: `out_sel` sequence 0,1,2,3,0, one per cycle, `out_data` matching each channel's word (e.g. 0xA000+i).
- MODE 0 burst: ch1 sends 3 words (last on the 3rd) while ch0 and ch2 are valid. Result: `out_sel`=1,1,1 then 2. ch1 drops `in_valid` for 2 cycles mid-burst: no transfers, ch0/ch2 stay blocked.
- Backpressure: `out_ready=0` for 3 cycles with the output full. `out_data`/`out_sel` stay stable, `in_ready=0`, no words lost or duplicated on release.
- MODE 1, ch3 and ch1 both valid: ch1 wins repeatedly and ch3 is served only when ch1 idles.
- Reset asserted during a ch2 burst: after release, ch0 wins first with `ptr=0` and no lock.
